// File: rtl/blit_cycle_sched.sv
// Blitter inner-loop memory cycle sequencer: source read, destination read, destination write.
// Owns the bus request, drives read/write requests and counts down the remaining iterations.
module blit_cycle_sched #(
   parameter int CNT_W    = 16,
   parameter int GAP_IDLE = 1
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             srcen,
   input  logic             dsten,
   input  logic [CNT_W-1:0] inner_cnt,
   input  logic             blit_back,
   input  logic             memready,
   input  logic             read_ack,
   output logic             blit_breq,
   output logic             readreq,
   output logic             writereq,
   output logic             sread,
   output logic             dread,
   output logic             step_inner,
   output logic [CNT_W-1:0] remain,
   output logic             busy,
   output logic             done
);

   typedef enum logic [3:0] {
      IDLE, BREQ, SRD, SRDW, DRD, DRDW, DWR, GAP, FIN
   } state_t;

   localparam logic [1:0] GAP_LOAD = 2'(GAP_IDLE > 0 ? GAP_IDLE - 1 : 0);

   state_t           state, state_next, first_phase;
   logic             src_l, dst_l, src_next, dst_next;
   logic [1:0]       gap_cnt, gap_cnt_next;
   logic [CNT_W-1:0] remain_next;
   logic             step_next;

   always_comb begin
      first_phase = DWR;
      if (src_l)
         first_phase = SRD;
      else if (dst_l)
         first_phase = DRD;
   end

   // Memory acceptance only counts while our registered request is actually on the bus.
   always_comb begin
      state_next   = state;
      gap_cnt_next = gap_cnt;
      remain_next  = remain;
      step_next    = 1'b0;
      src_next     = src_l;
      dst_next     = dst_l;
      case (state)
         IDLE: begin
            if (start) begin
               src_next    = srcen;
               dst_next    = dsten;
               remain_next = inner_cnt;
               state_next  = (inner_cnt != '0) ? BREQ : FIN;
            end
         end
         BREQ: begin
            if (blit_back)
               state_next = first_phase;
         end
         SRD: begin
            if (readreq && memready)
               state_next = SRDW;
         end
         SRDW: begin
            if (read_ack)
               state_next = dst_l ? DRD : DWR;
         end
         DRD: begin
            if (readreq && memready)
               state_next = DRDW;
         end
         DRDW: begin
            if (read_ack)
               state_next = DWR;
         end
         DWR: begin
            if (writereq && memready) begin
               step_next = 1'b1;
               if (remain != '0)
                  remain_next = remain - CNT_W'(1);
               if (remain_next == '0 || abort)
                  state_next = FIN;
               else if (GAP_IDLE == 0)
                  state_next = first_phase;
               else begin
                  state_next   = GAP;
                  gap_cnt_next = GAP_LOAD;
               end
            end
         end
         GAP: begin
            if (gap_cnt == 2'd0)
               state_next = first_phase;
            else
               gap_cnt_next = gap_cnt - 2'd1;
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         src_l   <= 1'b0;
         dst_l   <= 1'b0;
         gap_cnt <= 2'd0;
         remain  <= '0;
      end else begin
         state   <= state_next;
         src_l   <= src_next;
         dst_l   <= dst_next;
         gap_cnt <= gap_cnt_next;
         remain  <= remain_next;
      end
   end

   // Outputs follow the upcoming state so requests drop the cycle after acceptance;
   // done trails FIN by one cycle so it coincides with busy falling.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         blit_breq  <= 1'b0;
         readreq    <= 1'b0;
         writereq   <= 1'b0;
         sread      <= 1'b0;
         dread      <= 1'b0;
         step_inner <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         blit_breq  <= (state_next != IDLE) && (state_next != FIN);
         readreq    <= ((state_next == SRD) || (state_next == DRD)) && blit_back;
         writereq   <= (state_next == DWR) && blit_back;
         sread      <= (state_next == SRD) || (state_next == SRDW);
         dread      <= (state_next == DRD) || (state_next == DRDW);
         step_inner <= step_next;
         busy       <= state_next != IDLE;
         done       <= state == FIN;
      end
   end

endmodule

// File: tb/tb_blit_cycle_sched.sv
// Scoreboard bench for blit_cycle_sched: directed runs with a simple memory responder.
module tb_blit_cycle_sched;

   typedef struct packed {
      logic        is_done;
      logic [15:0] rem;
   } exp_t;

   logic        sys_clk = 1'b0;
   logic        reset, start, abort, srcen, dsten, blit_back, memready, read_ack;
   logic [15:0] inner_cnt;
   logic        blit_breq, readreq, writereq, sread, dread, step_inner, busy, done;
   logic [15:0] remain;

   int   compared = 0;
   int   mismatched = 0;
   exp_t sb[$];
   int   cyc_log[$];
   int   exp_log[$];
   int   rd_cycles = 0;
   int   breq_cycles = 0;
   int   req_cnt = 0;
   int   ack_cnt = 0;
   int   base, rd_snap, breq_snap;

   blit_cycle_sched #(.CNT_W(16), .GAP_IDLE(1)) dut (
      .sys_clk(sys_clk), .reset(reset), .start(start), .abort(abort),
      .srcen(srcen), .dsten(dsten), .inner_cnt(inner_cnt), .blit_back(blit_back),
      .memready(memready), .read_ack(read_ack), .blit_breq(blit_breq),
      .readreq(readreq), .writereq(writereq), .sread(sread), .dread(dread),
      .step_inner(step_inner), .remain(remain), .busy(busy), .done(done)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic d, input logic [15:0] cnt);
      @(negedge sys_clk);
      srcen = s; dsten = d; inner_cnt = cnt; start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      checkOutput("done_within_budget", 32'(done === 1'b1), 32'd1);
   endtask

   task automatic checkLog(input int from);
      checkOutput("cycle_count", 32'(cyc_log.size() - from), 32'(exp_log.size()));
      for (int i = 0; i < exp_log.size(); i++)
         if (from + i < cyc_log.size())
            checkOutput($sformatf("cycle_%0d", i), 32'(cyc_log[from + i]), 32'(exp_log[i]));
   endtask

   // Memory responder: memready after a request has been up two cycles, read_ack three later.
   initial begin
      memready = 1'b0;
      read_ack = 1'b0;
      forever begin
         @(negedge sys_clk);
         memready = 1'b0;
         read_ack = 1'b0;
         if (reset) begin
            req_cnt = 0;
            ack_cnt = 0;
         end else begin
            if (ack_cnt != 0) begin
               ack_cnt--;
               if (ack_cnt == 0) read_ack = 1'b1;
            end
            if (readreq || writereq) begin
               req_cnt++;
               if (req_cnt == 2) begin
                  memready = 1'b1;
                  req_cnt = 0;
                  cyc_log.push_back(writereq ? 3 : (sread ? 1 : 2));
                  if (readreq) ack_cnt = 3;
               end
            end else
               req_cnt = 0;
         end
      end
   end

   // Monitor: pops the scoreboard on every step_inner/done pulse.
   always @(negedge sys_clk) begin
      if (!reset) begin
         if (readreq) rd_cycles++;
         if (blit_breq) breq_cycles++;
         if ((readreq && writereq) || (sread && dread)) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL exclusivity: rr=%b wr=%b sr=%b dr=%b required no overlap",
                     readreq, writereq, sread, dread);
         end
         if (step_inner || done) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_pulse: step=%b done=%b with empty scoreboard", step_inner, done);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("pulse_kind", 32'(done), 32'(e.is_done));
               checkOutput("pulse_remain", 32'(remain), 32'(e.rem));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; srcen = 1'b0; dsten = 1'b0;
      inner_cnt = 16'd0; blit_back = 1'b1;
      repeat (3) @(negedge sys_clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_breq", 32'(blit_breq), 32'd0);
      checkOutput("reset_reqs", 32'({readreq, writereq, sread, dread}), 32'd0);
      checkOutput("reset_remain", 32'(remain), 32'd0);
      checkOutput("reset_pulses", 32'({step_inner, done}), 32'd0);
      reset = 1'b0;

      $display("[TB] run 1: src+dst, count 3");
      base = cyc_log.size();
      sb.push_back('{1'b0, 16'd2}); sb.push_back('{1'b0, 16'd1});
      sb.push_back('{1'b0, 16'd0}); sb.push_back('{1'b1, 16'd0});
      applyStimulus(1'b1, 1'b1, 16'd3);
      checkOutput("run1_busy", 32'(busy), 32'd1);
      checkOutput("run1_remain_loaded", 32'(remain), 32'd3);
      waitDone(400);
      checkOutput("run1_breq_at_done", 32'(blit_breq), 32'd0);
      checkOutput("run1_busy_at_done", 32'(busy), 32'd0);
      exp_log = '{1, 2, 3, 1, 2, 3, 1, 2, 3};
      checkLog(base);

      $display("[TB] run 2: write only, count 2");
      base = cyc_log.size();
      rd_snap = rd_cycles;
      sb.push_back('{1'b0, 16'd1}); sb.push_back('{1'b0, 16'd0}); sb.push_back('{1'b1, 16'd0});
      applyStimulus(1'b0, 1'b0, 16'd2);
      waitDone(300);
      checkOutput("run2_no_readreq", 32'(rd_cycles - rd_snap), 32'd0);
      exp_log = '{3, 3};
      checkLog(base);

      $display("[TB] run 3: zero count");
      breq_snap = breq_cycles;
      sb.push_back('{1'b1, 16'd0});
      applyStimulus(1'b1, 1'b1, 16'd0);
      checkOutput("run3_done_early", 32'(done), 32'd0);
      @(negedge sys_clk);
      checkOutput("run3_done", 32'(done), 32'd1);
      @(negedge sys_clk);
      checkOutput("run3_no_breq", 32'(breq_cycles - breq_snap), 32'd0);

      $display("[TB] run 4: bus loss during destination read");
      base = cyc_log.size();
      sb.push_back('{1'b0, 16'd1}); sb.push_back('{1'b0, 16'd0}); sb.push_back('{1'b1, 16'd0});
      applyStimulus(1'b0, 1'b1, 16'd2);
      for (int n = 0; n < 100 && !(readreq && dread); n++) @(negedge sys_clk);
      checkOutput("run4_reached_drd", 32'(readreq && dread), 32'd1);
      blit_back = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(negedge sys_clk);
         checkOutput($sformatf("run4_readreq_low_%0d", n), 32'(readreq), 32'd0);
         checkOutput($sformatf("run4_dread_held_%0d", n), 32'(dread), 32'd1);
         checkOutput($sformatf("run4_breq_held_%0d", n), 32'(blit_breq), 32'd1);
      end
      blit_back = 1'b1;
      @(negedge sys_clk);
      checkOutput("run4_readreq_back", 32'(readreq), 32'd1);
      waitDone(300);
      exp_log = '{2, 3, 2, 3};
      checkLog(base);

      $display("[TB] run 5: abort during source read wait");
      base = cyc_log.size();
      sb.push_back('{1'b0, 16'd4}); sb.push_back('{1'b1, 16'd4});
      applyStimulus(1'b1, 1'b0, 16'd5);
      for (int n = 0; n < 100 && !(sread && !readreq); n++) @(negedge sys_clk);
      checkOutput("run5_reached_srdw", 32'(sread && !readreq), 32'd1);
      abort = 1'b1;
      waitDone(300);
      abort = 1'b0;
      checkOutput("run5_remain", 32'(remain), 32'd4);
      rd_snap = rd_cycles;
      repeat (6) @(negedge sys_clk);
      checkOutput("run5_idle_busy", 32'(busy), 32'd0);
      checkOutput("run5_idle_no_reads", 32'(rd_cycles - rd_snap), 32'd0);
      exp_log = '{1, 3};
      checkLog(base);

      $display("[TB] run 6: reset during write");
      applyStimulus(1'b0, 1'b0, 16'd3);
      for (int n = 0; n < 100 && !writereq; n++) @(negedge sys_clk);
      checkOutput("run6_reached_dwr", 32'(writereq), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("run6_async_reqs", 32'({readreq, writereq, sread, dread}), 32'd0);
      checkOutput("run6_async_ctrl", 32'({blit_breq, busy, step_inner, done}), 32'd0);
      checkOutput("run6_async_remain", 32'(remain), 32'd0);
      @(negedge sys_clk);
      reset = 1'b0;
      base = cyc_log.size();
      sb.push_back('{1'b0, 16'd0}); sb.push_back('{1'b1, 16'd0});
      applyStimulus(1'b1, 1'b1, 16'd1);
      waitDone(300);
      exp_log = '{1, 2, 3};
      checkLog(base);

      repeat (3) @(negedge sys_clk);
      checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
